// File: rtl/risc_alu.sv
// ---------------------------------------------------------------------------
// risc_alu
//
// Execute-stage arithmetic/logic unit for the RISC core. Two unsigned
// operands and a 4-bit function select are evaluated combinationally every
// cycle; the result and the carry/borrow/shift-out flag are registered, so
// the unit has exactly one clock of latency and no handshake or enable.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset (clears outputs)
//   A         in   WIDTH  operand A (unsigned)
//   B         in   WIDTH  operand B (unsigned, ignored by shifts/rotates)
//   ALU_Sel   in   4      function select
//   ALU_Out   out  WIDTH  registered result
//   CarryOut  out  1      registered carry / borrow / shift-out flag
// ---------------------------------------------------------------------------
module risc_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    alu_op_e            sel_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               div_zero_s;
    logic [WIDTH-1:0]   divisor_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   result_s;
    logic               carry_s;

    assign sel_s = alu_op_e'(ALU_Sel);

    // Shared arithmetic datapath; the extra MSB of sum/diff is carry/borrow.
    always_comb begin
        sum_s      = {1'b0, A} + {1'b0, B};
        diff_s     = {1'b0, A} - {1'b0, B};
        prod_s     = {ZERO, A} * {ZERO, B};
        div_zero_s = (B == ZERO);
        // Divisor is forced non-zero so the divider never sees 0; the
        // divide-by-zero result is substituted in the function mux instead.
        if (div_zero_s) begin
            divisor_s = ONE;
        end else begin
            divisor_s = B;
        end
        quot_s = A / divisor_s;
    end

    // Function select mux: result and flag for the current operands.
    always_comb begin
        result_s = ZERO;
        carry_s  = 1'b0;
        case (sel_s)
            OP_ADD: begin
                result_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
            end
            OP_SUB: begin
                result_s = diff_s[WIDTH-1:0];
                carry_s  = diff_s[WIDTH];
            end
            OP_MUL: begin
                result_s = prod_s[WIDTH-1:0];
                carry_s  = |prod_s[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (div_zero_s) begin
                    result_s = ALL_ONES;
                    carry_s  = 1'b1;
                end else begin
                    result_s = quot_s;
                    carry_s  = 1'b0;
                end
            end
            OP_SHL: begin
                result_s = {A[WIDTH-2:0], 1'b0};
                carry_s  = A[WIDTH-1];
            end
            OP_SHR: begin
                result_s = {1'b0, A[WIDTH-1:1]};
                carry_s  = A[0];
            end
            OP_ROL:  result_s = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  result_s = {A[0], A[WIDTH-1:1]};
            OP_AND:  result_s = A & B;
            OP_OR:   result_s = A | B;
            OP_XOR:  result_s = A ^ B;
            OP_NOR:  result_s = ~(A | B);
            OP_NAND: result_s = ~(A & B);
            OP_XNOR: result_s = ~(A ^ B);
            OP_GT: begin
                if (A > B) begin
                    result_s = ONE;
                end else begin
                    result_s = ZERO;
                end
            end
            OP_EQ: begin
                if (A == B) begin
                    result_s = ONE;
                end else begin
                    result_s = ZERO;
                end
            end
            default: begin
                result_s = ZERO;
                carry_s  = 1'b0;
            end
        endcase
    end

    // Output registers: asynchronous clear, otherwise capture every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALU_Out  <= ZERO;
            CarryOut <= 1'b0;
        end else begin
            ALU_Out  <= result_s;
            CarryOut <= carry_s;
        end
    end

endmodule

// File: tb/tb_risc_alu.sv
// ---------------------------------------------------------------------------
// tb_risc_alu
//
// Self-checking bench for risc_alu. The driver applies operands on the
// falling edge and pushes the reference-model response into a queue; the
// monitor pops one entry per rising edge (after that edge settles) and
// compares it with the registered outputs. While reset is high the monitor
// instead expects all-zero outputs.
// ---------------------------------------------------------------------------
module tb_risc_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    wire  [7:0] ALU_Out;
    wire        CarryOut;

    typedef struct {
        int r;
        int c;
        int sel;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    risc_alu #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
        .CarryOut (CarryOut)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on 0..255 values.
    function automatic void model(input int a, input int b, input int sel,
                                  output int r, output int c);
        r = 0;
        c = 0;
        case (sel)
            0:  begin r = (a + b) % 256;       c = ((a + b) > 255) ? 1 : 0; end
            1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2:  begin r = (a * b) % 256;       c = ((a * b) > 255) ? 1 : 0; end
            3:  begin
                    if (b == 0) begin r = 255; c = 1; end
                    else        begin r = a / b; c = 0; end
                end
            4:  begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            5:  begin r = a / 2;         c = a % 2; end
            6:  r = (a * 2) % 256 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            15: r = (a == b) ? 1 : 0;
            default: begin r = 0; c = 0; end
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Apply one operand set on the falling edge and queue its expected result.
    task automatic drive(input int a, input int b, input int sel);
        exp_t e;
        @(negedge clk);
        reset   = 1'b0;
        A       = a[7:0];
        B       = b[7:0];
        ALU_Sel = sel[3:0];
        model(a, b, sel, e.r, e.c);
        e.sel = sel;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per rising edge, decoupled from the driver.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            chk("reset_out", int'(ALU_Out), 0);
            chk("reset_carry", int'(CarryOut), 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("out_sel%0d", e.sel), int'(ALU_Out), e.r);
            chk($sformatf("carry_sel%0d", e.sel), int'(CarryOut), e.c);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        A       = 8'h0A;
        B       = 8'h02;
        ALU_Sel = 4'd0;
        #1;
        chk("async_reset_out", int'(ALU_Out), 0);
        chk("async_reset_carry", int'(CarryOut), 0);
        repeat (3) @(posedge clk);

        // Release with the same operands; result must be 0x0C and stay there.
        drive(8'h0A, 8'h02, 0);
        drive(8'h0A, 8'h02, 0);
        drive(8'h0A, 8'h02, 0);

        // Directed boundary vectors.
        drive(8'hFF, 8'h01, 0);
        drive(8'hFF, 8'h01, 1);
        drive(8'h01, 8'h02, 1);
        drive(8'h10, 8'h20, 2);
        drive(8'h0A, 8'h02, 3);
        drive(8'h0A, 8'h00, 3);
        for (int s = 4; s <= 7; s++) drive(8'h81, int'($urandom_range(0, 255)), s);
        for (int s = 8; s <= 14; s++) drive(8'hF0, 8'h3C, s);
        drive(8'h55, 8'h55, 15);
        drive(8'h55, 8'h54, 15);
        drive(8'h3C, 8'hF0, 14);

        // Mid-operation reset pulse between edges: outputs drop at once.
        drive(8'hFF, 8'hFF, 2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("pulse_reset_out", int'(ALU_Out), 0);
        chk("pulse_reset_carry", int'(CarryOut), 0);
        #1;
        reset = 1'b0;
        drive(8'hC8, 8'h64, 0);

        // Randomized sequence; select changes every clock.
        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 40; i++) begin
            drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_alu.md
Name: risc_alu

Overview:
- 8-bit, 16-function arithmetic/logic unit for the RISC core execute stage.
- Two 8-bit operands and a 4-bit function select are evaluated combinationally.
- Result and carry flag are registered: one clock of latency.
- Feeds the core writeback/flag path.

Parameters:
- WIDTH, 8, operand and result width. All behaviour below is stated for 8; the implementation scales.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- A  input  8  operand A (unsigned)
- B  input  8  operand B (unsigned)
- ALU_Sel  input  4  function select
- ALU_Out  output  8  registered result
- CarryOut  output  1  registered carry/borrow/shift-out flag

Behaviour:
- Reset: reset high clears ALU_Out to 8'h00 and CarryOut to 0 immediately, independent of clk. Outputs hold these values while reset is high. The first capture occurs on the first rising clk edge after reset deasserts.
- Latency: on each rising clk edge, the registers capture f(A, B, ALU_Sel) using the input values present at that edge. Outputs are stable for the full following cycle. There is no handshake or enable; the unit computes every cycle.
- Functions (result; CarryOut):
  - 0 ADD: A+B mod 256; bit 8 of the 9-bit sum.
  - 1 SUB: A-B mod 256; 1 when A<B (borrow).
  - 2 MUL: low 8 bits of A*B; 1 when the product is greater than 255.
  - 3 DIV: A/B truncated; 0. If B==0, result is 8'hFF and CarryOut is 1.
  - 4 SHL: A<<1, zero fill; CarryOut = A[7].
  - 5 SHR: A>>1 logical, zero fill; CarryOut = A[0].
  - 6 ROL: {A[6:0],A[7]}; 0.
  - 7 ROR: {A[0],A[7:1]}; 0.
  - 8 AND: A&B; 0.
  - 9 OR: A|B; 0.
  - 10 XOR: A^B; 0.
  - 11 NOR: ~(A|B); 0.
  - 12 NAND: ~(A&B); 0.
  - 13 XNOR: ~(A^B); 0.
  - 14 GT: 8'h01 if A>B (unsigned), else 8'h00; 0.
  - 15 EQ: 8'h01 if A==B, else 8'h00; 0.
- Operand B is ignored for functions 4 through 7.
- Width rules: all arithmetic is unsigned. Wrap-around is modulo 256; overflow information appears only on CarryOut as defined above.
- Reset mid-operation: the result in flight is discarded and outputs go to 0 asynchronously. Nothing is retained across reset.
- X/undefined select values never occur in legal use. The default branch of the selector yields 8'h00 and CarryOut 0.

Test Plan:
- Reset: hold reset high while driving A=8'h0A, B=8'h02, ALU_Sel=0 -> ALU_Out=0 and CarryOut=0 throughout; one edge after release -> ALU_Out=12 (8'h0C), CarryOut=0, stable thereafter.
- ADD and SUB wrap: A=8'hFF, B=8'h01, sel 0 -> 8'h00, CarryOut=1. Same operands with sel 1 -> 8'hFE, CarryOut=0. A=8'h01, B=8'h02, sel 1 -> 8'hFF, CarryOut=1.
- MUL and DIV: A=8'h10, B=8'h20, sel 2 -> 8'h00, CarryOut=1. A=8'h0A, B=8'h02, sel 3 -> 8'h05. Sel 3 with B=0 -> 8'hFF, CarryOut=1.
- Shift and rotate with A=8'h81: sel 4 -> 8'h02, CarryOut=1; sel 5 -> 8'h40, CarryOut=1; sel 6 -> 8'h03; sel 7 -> 8'hC0.
- Logic and compare with A=8'hF0, B=8'h3C: sel 8 -> 8'h30; sel 9 -> 8'hFC; sel 10 -> 8'hCC; sel 11 -> 8'h03; sel 12 -> 8'hCF; sel 13 -> 8'h33; sel 14 -> 8'h01. A=B=8'h55 with sel 15 -> 8'h01.
- Latency and mid-operation reset: change ALU_Sel every clock and confirm each output equals the function of the inputs sampled at the previous edge. Pulse reset between edges -> outputs drop to 0 before the next edge.
